// File: rtl/instruction_packer.sv
// -----------------------------------------------------------------------------
// instruction_packer
//
// Assembles received bytes into 32-bit GPU instructions, rejects words with an
// invalid opcode, buffers good words in a small FIFO and issues them to the
// pixel generator with a minimum idle gap after each issue. The gap after a
// SET_SPRITE (opcode 8) is longer, so that its read-modify-write finishes
// before the next instruction arrives.
//
// Ports
//   i_clk               : clock
//   i_reset_n           : asynchronous active-low reset
//   i_byte              : received byte
//   i_byte_valid        : one-cycle strobe qualifying i_byte
//   o_instruction       : issued instruction word, held between issues
//   o_instruction_ready : one-cycle issue strobe
//   o_busy              : partial word, pending push, FIFO entry or active gap
//   o_error             : one-cycle error strobe
//   o_error_code        : 1 = bad opcode, 2 = overflow, 3 = timeout (held)
//
// Issue FSM
//   state    | meaning
//   ST_IDLE  | waiting for a FIFO entry; pops as soon as one is present
//   ST_ISSUE | o_instruction_ready high for this cycle; gap counter is loaded
//   ST_GAP   | gap counter counts down; at terminal count pop the next entry
//            | directly if one is waiting, otherwise return to ST_IDLE
// -----------------------------------------------------------------------------
module instruction_packer #(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned SPRITE_GAP     = 8,
    parameter int unsigned BASE_GAP       = 1
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic [7:0]  i_byte,
    input  logic        i_byte_valid,
    output logic [31:0] o_instruction,
    output logic        o_instruction_ready,
    output logic        o_busy,
    output logic        o_error,
    output logic [1:0]  o_error_code
);

    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned TMO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned GAP_MAX = (SPRITE_GAP > BASE_GAP) ? SPRITE_GAP : BASE_GAP;
    localparam int unsigned GAP_W   = $clog2(GAP_MAX + 1);

    localparam logic [3:0] OP_SET_SPRITE = 4'd8;
    localparam logic [1:0] ERR_OPCODE    = 2'd1;
    localparam logic [1:0] ERR_OVERFLOW  = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // byte assembly
    logic [1:0]       byte_cnt;
    logic [23:0]      partial;
    logic [TMO_W-1:0] tmo_cnt;
    logic             cmp_valid;
    logic [31:0]      cmp_word;

    // fifo
    logic [31:0]      mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    // issue
    state_t           state;
    logic [GAP_W-1:0] gap_cnt;

    logic [31:0] full_word;
    logic        word_done;
    logic        opcode_ok;
    logic        tmo_expire;
    logic        fifo_empty;
    logic        can_pop;
    logic        pop;
    logic        push_ok;

    assign full_word  = {i_byte, partial};
    assign word_done  = i_byte_valid && (byte_cnt == 2'd3);
    assign opcode_ok  = (full_word[3:0] != 4'd0) && (full_word[3:0] <= 4'd8);

    // An arriving byte always beats an expiry on the same edge.
    assign tmo_expire = !i_byte_valid && (byte_cnt != 2'd0) && (tmo_cnt == TMO_W'(1));

    assign fifo_empty = (count == '0);
    assign can_pop    = (state == ST_IDLE) ||
                        ((state == ST_GAP) && (gap_cnt <= GAP_W'(1)));
    assign pop        = can_pop && !fifo_empty;

    // A full FIFO still accepts a push when an entry leaves on the same edge.
    assign push_ok    = cmp_valid && ((count < CNT_W'(FIFO_DEPTH)) || pop);

    assign o_busy     = (byte_cnt != 2'd0) || cmp_valid || !fifo_empty || (state != ST_IDLE);

    // -------------------------------------------------------------------------
    // Byte assembly and timeout (down-counter reloaded on every byte)
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            byte_cnt  <= 2'd0;
            partial   <= 24'd0;
            tmo_cnt   <= '0;
            cmp_valid <= 1'b0;
            cmp_word  <= 32'd0;
        end else begin
            cmp_valid <= word_done && opcode_ok;
            if (word_done) begin
                cmp_word <= full_word;
            end
            if (i_byte_valid) begin
                byte_cnt <= byte_cnt + 2'd1;
                tmo_cnt  <= TMO_W'(TIMEOUT_CYCLES);
                case (byte_cnt)
                    2'd0:    partial[7:0]   <= i_byte;
                    2'd1:    partial[15:8]  <= i_byte;
                    2'd2:    partial[23:16] <= i_byte;
                    default: ;
                endcase
            end else if (byte_cnt != 2'd0) begin
                if (tmo_expire) begin
                    byte_cnt <= 2'd0;
                    tmo_cnt  <= '0;
                end else begin
                    tmo_cnt  <= tmo_cnt - TMO_W'(1);
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Error reporting. Sources cannot coincide: a bad opcode and a timeout are
    // decided by the byte counter on the same edge and are exclusive, and an
    // overflow lands one edge after a completion, when no partial word exists.
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_error      <= 1'b0;
            o_error_code <= 2'd0;
        end else begin
            o_error <= 1'b0;
            if (word_done && !opcode_ok) begin
                o_error      <= 1'b1;
                o_error_code <= ERR_OPCODE;
            end else if (cmp_valid && !push_ok) begin
                o_error      <= 1'b1;
                o_error_code <= ERR_OVERFLOW;
            end else if (tmo_expire) begin
                o_error      <= 1'b1;
                o_error_code <= ERR_TIMEOUT;
            end
        end
    end

    // -------------------------------------------------------------------------
    // FIFO storage (contents need no reset; pointers and count define validity)
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= cmp_word;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Issue FSM. Loading gap_cnt with the gap and popping at its terminal count
    // spaces consecutive strobes by gap+1 cycles.
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state               <= ST_IDLE;
            gap_cnt             <= '0;
            o_instruction       <= 32'd0;
            o_instruction_ready <= 1'b0;
        end else begin
            o_instruction_ready <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        o_instruction       <= mem[rd_ptr];
                        o_instruction_ready <= 1'b1;
                        state               <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    gap_cnt <= (o_instruction[3:0] == OP_SET_SPRITE) ?
                               GAP_W'(SPRITE_GAP) : GAP_W'(BASE_GAP);
                    state   <= ST_GAP;
                end
                ST_GAP: begin
                    if (gap_cnt <= GAP_W'(1)) begin
                        gap_cnt <= '0;
                        if (pop) begin
                            o_instruction       <= mem[rd_ptr];
                            o_instruction_ready <= 1'b1;
                            state               <= ST_ISSUE;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
